sigmoid_lut_loader: RTL

- Runtime writer for the RAM-backed sigmoid lookup table. Replaces the build-time memory image with contents streamed in over a valid/ready interface.
- Accepts exactly DEPTH data words after a start pulse. Issues one registered write per word, at sequential addresses from 0 to DEPTH-1.
- Raises a sticky loaded flag, which the neuron datapath uses to gate activation lookups.
- Sits between the host/config stream and the write port of the sigmoid LUT RAM.

---
 rtl/sigmoid_lut_pkg.sv | 18 +
 rtl/sigmoid_lut_addr_ctr.sv | 31 +++
 rtl/sigmoid_lut_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sigmoid_lut_pkg.sv
// Shared types and defaults for the sigmoid LUT and its runtime loader.
// Default widths are reused by the LUT RAM so both sides agree on geometry.
package sigmoid_lut_pkg;

    localparam int unsigned LUT_ADDR_W = 10;
    localparam int unsigned LUT_DATA_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    typedef logic [LUT_ADDR_W-1:0] lut_addr_t;
    typedef logic [LUT_DATA_W-1:0] lut_data_t;

endpackage

// File: rtl/sigmoid_lut_addr_ctr.sv
// LUT write-address counter: synchronous clear, increment, and a flag for the
// final entry of a pass. Holds at DEPTH-1 so it never wraps within a pass.
module sigmoid_lut_addr_ctr
    import sigmoid_lut_pkg::*;
#(
    parameter int unsigned ADDR_W = LUT_ADDR_W,
    parameter int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              incr,
    output logic [ADDR_W-1:0] count,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    assign last = (count == LAST_ADDR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr && !last) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sigmoid_lut_loader.sv
// Streams DEPTH words into the sigmoid LUT RAM write port after a start pulse.
// Optional checksum word after the data: define SIGMOID_LUT_LOADER_CHECKSUM_EN.
module sigmoid_lut_loader
    import sigmoid_lut_pkg::*;
#(
    parameter int unsigned ADDR_W = LUT_ADDR_W,
    parameter int unsigned DATA_W = LUT_DATA_W,
    parameter int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              lut_we,
    output logic [ADDR_W-1:0] lut_waddr,
    output logic [DATA_W-1:0] lut_wdata,
    output logic              busy,
    output logic              done,
    output logic              loaded,
    output logic              err
);

    loader_state_t     state_q, state_d;
    logic              loaded_q, loaded_d;
    logic              we_d;
    logic              ctr_clear, ctr_incr, ctr_last;
    logic [ADDR_W-1:0] ctr_count;

`ifdef SIGMOID_LUT_LOADER_CHECKSUM_EN
    logic              err_q, err_d;
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    sigmoid_lut_addr_ctr #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr_ctr (
        .clock (clock),
        .reset (reset),
        .clear (ctr_clear),
        .incr  (ctr_incr),
        .count (ctr_count),
        .last  (ctr_last)
    );

    always_comb begin
        state_d   = state_q;
        loaded_d  = loaded_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        we_d      = 1'b0;
        ctr_clear = 1'b0;
        ctr_incr  = 1'b0;
`ifdef SIGMOID_LUT_LOADER_CHECKSUM_EN
        err_d     = err_q;
        sum_d     = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    ctr_clear = 1'b1;
                    loaded_d  = 1'b0;
`ifdef SIGMOID_LUT_LOADER_CHECKSUM_EN
                    err_d     = 1'b0;
                    sum_d     = '0;
`endif
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    we_d     = 1'b1;
                    ctr_incr = 1'b1;
`ifdef SIGMOID_LUT_LOADER_CHECKSUM_EN
                    sum_d    = sum_q + in_data;
                    if (ctr_last) state_d = CHECK;
`else
                    if (ctr_last) state_d = DONE;
`endif
                end
            end
`ifdef SIGMOID_LUT_LOADER_CHECKSUM_EN
            CHECK: begin
                // The checksum word is consumed but never written to the LUT.
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    err_d   = (in_data != sum_q);
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
`ifdef SIGMOID_LUT_LOADER_CHECKSUM_EN
                loaded_d = !err_q;
`else
                loaded_d = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            loaded_q  <= 1'b0;
            lut_we    <= 1'b0;
            lut_waddr <= '0;
            lut_wdata <= '0;
        end else begin
            state_q  <= state_d;
            loaded_q <= loaded_d;
            lut_we   <= we_d;
            if (we_d) begin
                lut_waddr <= ctr_count;
                lut_wdata <= in_data;
            end
        end
    end

`ifdef SIGMOID_LUT_LOADER_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
            sum_q <= '0;
        end else begin
            err_q <= err_d;
            sum_q <= sum_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign loaded = loaded_q;

endmodule
